// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
//
// Shared definitions for the APB register slave:
//   - default parameter values for apb_if / apb_regfile
//   - the transfer-phase FSM state enum
//   - error code constants reported by the address decoder
//   - a small helper that folds the individual decode checks into a code
//
// No ports; this file is imported by apb_if and apb_regfile.
// ----------------------------------------------------------------------------
package apb_pkg;

    // Default parameter values
    localparam int DEFAULT_ADDR_W      = 8;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_NUM_REGS    = 16;
    localparam int DEFAULT_WAIT_CYCLES = 0;

    // The wait-state counter has to reach at most 15.
    localparam int WAIT_CNT_W = 4;

    // Transfer phase as seen by the slave.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Decode error codes; bits can be set together, so an access that is
    // both misaligned and out of range reports both.
    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_RANGE      = 2'b10;

    // Combine the individual decode checks into one error code.
    function automatic logic [1:0] decode_err(input logic misaligned,
                                              input logic out_of_range);
        logic [1:0] code;
        code = ERR_NONE;
        if (misaligned) begin
            code = code | ERR_MISALIGNED;
        end
        if (out_of_range) begin
            code = code | ERR_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/apb_regfile.sv
// ----------------------------------------------------------------------------
// apb_regfile
//
// NUM_REGS x DATA_W register storage with per-byte write strobes.
// Write port is synchronous (commits on the rising edge); read port is
// combinational so a value written on one edge is visible in the very next
// cycle.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   synchronous active-high reset, clears every register
//   we       in   write enable for this cycle
//   waddr    in   IDX_W   register index to write
//   wdata    in   DATA_W  write data
//   wstrb    in   DATA_W/8 byte enables for the write
//   raddr    in   IDX_W   register index to read
//   rdata    out  DATA_W  contents of register raddr (0 if raddr is unmapped)
// ----------------------------------------------------------------------------
module apb_regfile
    import apb_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int IDX_W    = DEFAULT_ADDR_W - 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Storage: reset clears everything, otherwise only the strobed bytes of
    // the addressed register are updated. The index is matched against each
    // entry instead of used directly, so NUM_REGS need not be a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == IDX_W'(i)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wstrb[b]) begin
                            regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Combinational read; unmapped indices return zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_if.sv
// ----------------------------------------------------------------------------
// apb_if
//
// APB slave exposing NUM_REGS 32-bit registers. Tracks the transfer phase,
// decodes the address, inserts WAIT_CYCLES wait states, reports decode
// errors through pslverr and flags master protocol violations.
//
// Ports:
//   clk_i       in   clock, all state updates on the rising edge
//   rst_i       in   synchronous active-high reset
//   psel        in   slave select
//   penable     in   access phase
//   pwrite      in   1 = write, 0 = read
//   paddr       in   ADDR_W   byte address
//   pwdata      in   DATA_W   write data
//   pstrb       in   DATA_W/8 byte write strobes
//   prdata      out  DATA_W   read data, non-zero only on a good read completion
//   pready      out  transfer complete (one cycle per transfer)
//   pslverr     out  error response, only together with pready
//   prot_err_o  out  one-cycle pulse on a protocol violation
// ----------------------------------------------------------------------------
module apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_REGS    = DEFAULT_NUM_REGS,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  prot_err_o
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;

    apb_state_e               state_q;
    apb_state_e               state_d;
    apb_state_e               phase;

    logic [WAIT_CNT_W-1:0]    wait_cnt_q;
    logic                     wait_done;

    logic [ADDR_W-1:0]        addr_q;
    logic                     write_q;
    logic [DATA_W-1:0]        wdata_q;
    logic [STRB_W-1:0]        strb_q;
    logic                     bus_changed;

    logic [IDX_W-1:0]         index;
    logic [1:0]               err_code;
    logic                     is_err;

    logic                     complete;
    logic                     rf_we;
    logic [DATA_W-1:0]        rf_rdata;

    // The setup cycle of a transfer is the cycle in which the master first
    // shows psel with penable low. That cycle cannot be predicted by a
    // registered state, so the current phase is the registered state with a
    // look-ahead: IDLE plus psel & !penable is already SETUP. This lets the
    // access cycle follow immediately and gives pready in the second cycle
    // of a zero-wait transfer. The same look-ahead covers back-to-back
    // transfers: a completion returns to IDLE, and a new setup in the next
    // cycle is recognised as SETUP straight away.
    always_comb begin
        phase = state_q;
        if (state_q == IDLE && psel && !penable) begin
            phase = SETUP;
        end
    end

    // The address and controls are frozen at setup; any difference during
    // the access phase is a protocol violation.
    assign bus_changed = (paddr  != addr_q)  ||
                         (pwrite != write_q) ||
                         (pwdata != wdata_q) ||
                         (pstrb  != strb_q);

    assign wait_done = (wait_cnt_q == WAIT_CNT_W'(WAIT_CYCLES));

    // Address decode on the captured address.
    assign index = addr_q[ADDR_W-1:2];

    always_comb begin
        err_code = decode_err(addr_q[1:0] != 2'b00,
                              {1'b0, index} >= (IDX_W + 1)'(NUM_REGS));
    end

    assign is_err = (err_code != ERR_NONE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Losing psel or a changing bus abandons the transfer.
    always_comb begin
        state_d = state_q;
        case (phase)
            IDLE: begin
                state_d = IDLE;
            end
            SETUP: begin
                state_d = psel ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!psel || bus_changed || wait_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = ACCESS;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: capture the bus at setup and count wait states
    // while the access phase continues.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
        end else begin
            if (phase == SETUP) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                strb_q  <= pstrb;
            end
            if (phase == ACCESS && state_d == ACCESS) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end
        end
    end

    // Outputs. Everything is gated by rst_i so a reset landing on what would
    // have been the completion cycle produces neither a pready pulse nor a
    // register write.
    always_comb begin
        complete   = !rst_i && (phase == ACCESS) && psel && !bus_changed && wait_done;
        pready     = complete;
        pslverr    = complete && is_err;
        rf_we      = complete && write_q && !is_err;
        prdata     = '0;
        if (complete && !write_q && !is_err) begin
            prdata = rf_rdata;
        end
        prot_err_o = !rst_i &&
                     (((phase == IDLE)   && penable) ||
                      ((phase == SETUP)  && !psel)   ||
                      ((phase == ACCESS) && (!psel || bus_changed)));
    end

    apb_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (IDX_W)
    ) u_regfile (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we       (rf_we),
        .waddr    (index),
        .wdata    (wdata_q),
        .wstrb    (strb_q),
        .raddr    (index),
        .rdata    (rf_rdata)
    );

endmodule

// File: tb/tb_apb_if.sv
// ----------------------------------------------------------------------------
// tb_apb_if
//
// Drives two apb_if instances (zero wait states and three wait states) from
// one shared APB bus; psel/penable are routed to whichever instance is
// targeted. Each transfer pushes its expected response into a queue and a
// monitor pops and compares whenever either instance raises pready.
// ----------------------------------------------------------------------------
module tb_apb_if;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        sel3;

    logic        psel0, penable0, psel3, penable3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3;
    logic        pslverr0, pslverr3;
    logic        prot0, prot3;

    int          num_checks = 0;
    int          num_errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    assign psel0    = psel    && !sel3;
    assign penable0 = penable && !sel3;
    assign psel3    = psel    &&  sel3;
    assign penable3 = penable &&  sel3;

    apb_if #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .NUM_REGS    (16),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk_i      (clk),
        .rst_i      (rst),
        .psel       (psel0),
        .penable    (penable0),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata0),
        .pready     (pready0),
        .pslverr    (pslverr0),
        .prot_err_o (prot0)
    );

    apb_if #(
        .ADDR_W      (8),
        .DATA_W      (32),
        .NUM_REGS    (16),
        .WAIT_CYCLES (3)
    ) dut3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .psel       (psel3),
        .penable    (penable3),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .prdata     (prdata3),
        .pready     (pready3),
        .pslverr    (pslverr3),
        .prot_err_o (prot3)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // One APB transfer to the selected instance. The task returns at the
    // falling edge of the completion cycle with the bus still driven, so a
    // following call starts a back-to-back transfer.
    task automatic applyStimulus(input logic tgt3, input logic wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic [3:0] strb,
                                 input logic [31:0] exp_data, input logic exp_err,
                                 input int exp_wait);
        exp_t e;
        int   waited;
        logic done;
        @(posedge clk); #1;
        sel3    = tgt3;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
        pstrb   = strb;
        e.data  = exp_data;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        checkOutput("setup_pready", {31'b0, (tgt3 ? pready3 : pready0)}, 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        waited  = 0;
        done    = 1'b0;
        while (!done && waited < 20) begin
            @(negedge clk);
            if (tgt3 ? pready3 : pready0) begin
                done = 1'b1;
            end else begin
                waited++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            num_checks++;
            num_errors++;
            $display("[TB] FAIL pready_timeout: got no pready in %0d cycles, required pready", waited);
        end else begin
            checkOutput("pready_latency", 32'(waited), 32'(exp_wait));
        end
    endtask

    task automatic idleBus();
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Protocol violations on the zero-wait instance:
    //   0: psel dropped during the access phase of a write to 0x0C
    //   1: penable high while idle
    //   2: pwdata changed between setup and access of a write to 0x10
    task automatic protViolation(input int mode);
        idleBus();
        sel3 = 1'b0;
        if (mode != 1) begin
            @(posedge clk); #1;
            psel    = 1'b1;
            penable = 1'b0;
            pwrite  = 1'b1;
            paddr   = (mode == 0) ? 8'h0C : 8'h10;
            pwdata  = 32'h5A5A_5A5A;
            pstrb   = 4'hF;
        end
        @(posedge clk); #1;
        penable = 1'b1;
        if (mode == 0) psel = 1'b0;
        if (mode == 2) pwdata = 32'h2222_2222;
        @(negedge clk);
        checkOutput("prot_err_pulse", {31'b0, prot0}, 32'd1);
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        checkOutput("prot_err_single", {31'b0, prot0}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_prdata"},  prdata0, 32'd0);
        checkOutput({tag, "_pready"},  {31'b0, pready0}, 32'd0);
        checkOutput({tag, "_pslverr"}, {31'b0, pslverr0}, 32'd0);
        checkOutput({tag, "_prot"},    {31'b0, prot0}, 32'd0);
        checkOutput({tag, "_prot3"},   {31'b0, prot3}, 32'd0);
    endtask

    // Monitor: pops the expected response whenever an instance completes,
    // and otherwise requires quiet read-data / error outputs.
    always @(negedge clk) begin
        if (pready0 || pready3) begin
            if (exp_q.size() == 0) begin
                num_checks++;
                num_errors++;
                $display("[TB] FAIL unexpected_pready: got pready=1, required no completion");
            end else begin
                mon_e = exp_q.pop_front();
                if (pready3) begin
                    checkOutput("prdata3", prdata3, mon_e.data);
                    checkOutput("pslverr3", {31'b0, pslverr3}, {31'b0, mon_e.err});
                end else begin
                    checkOutput("prdata0", prdata0, mon_e.data);
                    checkOutput("pslverr0", {31'b0, pslverr0}, {31'b0, mon_e.err});
                end
            end
        end
        if (!pready0) begin
            checkOutput("idle_prdata0", prdata0 | {31'b0, pslverr0}, 32'd0);
        end
        if (!pready3) begin
            checkOutput("idle_prdata3", prdata3 | {31'b0, pslverr3}, 32'd0);
        end
    end

    // Stimulus sequence.
    initial begin
        rst     = 1'b1;
        sel3    = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        pstrb   = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("after_reset");

        // Full write then back-to-back read of the same register.
        applyStimulus(1'b0, 1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h04, 32'h0,        4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        // Partial overwrite via strobes.
        applyStimulus(1'b0, 1'b1, 8'h08, 32'h1122_3344, 4'hF, 32'h0,         1'b0, 0);
        applyStimulus(1'b0, 1'b1, 8'h08, 32'hAABB_CCDD, 4'h3, 32'h0,         1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h08, 32'h0,         4'h0, 32'h1122_CCDD, 1'b0, 0);
        // Decode errors leave registers untouched.
        applyStimulus(1'b0, 1'b1, 8'h40, 32'h1234_5678, 4'hF, 32'h0,         1'b1, 0);
        applyStimulus(1'b0, 1'b1, 8'h06, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 0);
        applyStimulus(1'b0, 1'b0, 8'h40, 32'h0,         4'h0, 32'h0,         1'b1, 0);
        applyStimulus(1'b0, 1'b0, 8'h04, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h00, 32'h0,         4'h0, 32'h0,         1'b0, 0);
        // Last mapped register with a sparse strobe pattern.
        applyStimulus(1'b0, 1'b1, 8'h3C, 32'hCAFE_F00D, 4'hA, 32'h0,         1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h3C, 32'h0,         4'h0, 32'hCA00_F000, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h02, 32'h0,         4'h0, 32'h0,         1'b1, 0);

        // Protocol violations never write.
        protViolation(0);
        applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        protViolation(1);
        protViolation(2);
        applyStimulus(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 32'h0, 1'b0, 0);

        // Reset in the access cycle of a write.
        idleBus();
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'h0C;
        pwdata  = 32'h9999_9999;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        checkAllZero("mid_reset");
        @(posedge clk); #1;
        rst     = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        checkAllZero("post_abort");
        applyStimulus(1'b0, 1'b0, 8'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h04, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        applyStimulus(1'b0, 1'b0, 8'h08, 32'h0, 4'h0, 32'h0, 1'b0, 0);
        idleBus();

        // Three wait states.
        applyStimulus(1'b1, 1'b0, 8'h00, 32'h0,         4'h0, 32'h0,         1'b0, 3);
        applyStimulus(1'b1, 1'b1, 8'h08, 32'h0000_ABCD, 4'hF, 32'h0,         1'b0, 3);
        applyStimulus(1'b1, 1'b0, 8'h08, 32'h0,         4'h0, 32'h0000_ABCD, 1'b0, 3);
        idleBus();
        sel3 = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("pending_responses", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
